shift_seq_ctrl: RTL



---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_stage.sv | 40 ++++
 rtl/shift_seq_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings and defaults for the iterative shift sequencer
// Contents:
//   op_e     : shift operation encodings (SLL, SRL, SRA, ROR)
//   state_e  : sequencer FSM states
//   WIDTH_DEF, SHW_DEF : default datapath and shift-amount widths
package shift_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - combinational shift of data by 2^k for one binary-weighted stage
// Ports:
//   data    in  : value to shift
//   k       in  : stage index, shift distance is 2^k
//   op      in  : operation (SLL, SRL, SRA, ROR)
//   shifted out : shifted value
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   k,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] shifted
);

    // 2^k never exceeds WIDTH/2, so it always fits in SHW bits.
    logic [SHW-1:0]          sh;
    logic [2*WIDTH-1:0]      rot_wide;
    logic signed [WIDTH-1:0] sra_val;

    assign sh       = SHW'(1) << k;
    // Rotation: shift a doubled copy right and keep the low half.
    assign rot_wide = {data, data} >> sh;
    assign sra_val  = $signed(data) >>> sh;

    always_comb begin
        shifted = data;
        case (op)
            OP_SLL: shifted = data << sh;
            OP_SRL: shifted = data >> sh;
            OP_SRA: shifted = sra_val;
            OP_ROR: shifted = rot_wide[WIDTH-1:0];
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - iterative shift sequencer with busy stall and valid/ready result
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, op, A, B : request (A[SHW-1:0] is the amount, B the data)
//   flush           : abort, returns to IDLE and overrides start/res_ready
//   in_ready        : request may be accepted (IDLE and no flush)
//   busy            : SHIFT or DONE, stalls the pipeline
//   res_valid, res_ready, res : result handshake; res holds outside DONE
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             in_ready,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res
);

    state_e           state, state_next;
    logic [WIDTH-1:0] data;
    logic [SHW-1:0]   amt;
    logic [SHW-1:0]   k;
    logic [1:0]       op_r;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_step;
    logic [SHW-1:0]   mask;
    logic [SHW-1:0]   amt_clr;
    logic [SHW-1:0]   amt_in;
    logic             accept;
    logic             step;

    // Only the low SHW bits of A select the amount.
    logic             unused_a_hi;
    assign unused_a_hi = ^A[WIDTH-1:SHW];
    assign amt_in      = A[SHW-1:0];

    shift_stage #(.WIDTH(WIDTH), .SHW(SHW)) u_stage (
        .data    (data),
        .k       (k),
        .op      (op_r),
        .shifted (shifted)
    );

    assign mask      = SHW'(1) << k;
    assign amt_clr   = amt & ~mask;
    assign data_step = (|(amt & mask)) ? shifted : data;
    assign accept    = (state == ST_IDLE) && start && !flush;
    assign step      = (state == ST_SHIFT) && !flush;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        res_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !flush;
                if (accept) begin
                    state_next = (amt_in == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (amt_clr == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (flush || res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            data  <= '0;
            amt   <= '0;
            k     <= '0;
            op_r  <= '0;
            res   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                data <= B;
                amt  <= amt_in;
                op_r <= op;
                k    <= '0;
                // A zero amount goes straight to DONE with the data untouched.
                if (amt_in == '0) begin
                    res <= B;
                end
            end else if (step) begin
                data <= data_step;
                amt  <= amt_clr;
                k    <= k + SHW'(1);
                if (amt_clr == '0) begin
                    res <= data_step;
                end
            end
        end
    end

endmodule
